// File: rtl/axil_cmd_master_if.sv
// Bus bundle for axil_cmd_master: the command stream, the AXI-Lite master
// channels and the response stream.
// master modport: the bridge's view (drives AXI-Lite requests and responses).
// slave modport:  the opposite side (command source, AXI-Lite slave, response sink).
interface axil_cmd_master_if #(
    parameter int unsigned CFGAW = 32,
    parameter int unsigned CFGDW = 32
);
    // Command stream: {write, addr, data}
    logic [CFGAW+CFGDW:0] s_cmd_tdata;
    logic                 s_cmd_tvalid;
    logic                 s_cmd_tready;

    // AXI-Lite write address / data / response
    logic [CFGAW-1:0]     m_axil_awaddr;
    logic                 m_axil_awvalid;
    logic                 m_axil_awready;
    logic [CFGDW-1:0]     m_axil_wdata;
    logic                 m_axil_wvalid;
    logic                 m_axil_wready;
    logic [1:0]           m_axil_bresp;
    logic                 m_axil_bvalid;
    logic                 m_axil_bready;

    // AXI-Lite read address / data
    logic [CFGAW-1:0]     m_axil_araddr;
    logic                 m_axil_arvalid;
    logic                 m_axil_arready;
    logic [CFGDW-1:0]     m_axil_rdata;
    logic [1:0]           m_axil_rresp;
    logic                 m_axil_rvalid;
    logic                 m_axil_rready;

    // Response stream
    logic [CFGDW-1:0]     m_rsp_tdata;
    logic [1:0]           m_rsp_tresp;
    logic                 m_rsp_twrite;
    logic                 m_rsp_tvalid;
    logic                 m_rsp_tready;

    modport master (
        input  s_cmd_tdata, s_cmd_tvalid,
        output s_cmd_tready,
        output m_axil_awaddr, m_axil_awvalid,
        input  m_axil_awready,
        output m_axil_wdata, m_axil_wvalid,
        input  m_axil_wready,
        input  m_axil_bresp, m_axil_bvalid,
        output m_axil_bready,
        output m_axil_araddr, m_axil_arvalid,
        input  m_axil_arready,
        input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output m_axil_rready,
        output m_rsp_tdata, m_rsp_tresp, m_rsp_twrite, m_rsp_tvalid,
        input  m_rsp_tready
    );

    modport slave (
        output s_cmd_tdata, s_cmd_tvalid,
        input  s_cmd_tready,
        input  m_axil_awaddr, m_axil_awvalid,
        output m_axil_awready,
        input  m_axil_wdata, m_axil_wvalid,
        output m_axil_wready,
        output m_axil_bresp, m_axil_bvalid,
        input  m_axil_bready,
        input  m_axil_araddr, m_axil_arvalid,
        output m_axil_arready,
        output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  m_axil_rready,
        input  m_rsp_tdata, m_rsp_tresp, m_rsp_twrite, m_rsp_tvalid,
        output m_rsp_tready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Command-to-AXI-Lite bridge: one AXI-Lite transaction per command, one
// transaction in flight, result returned on a response stream.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        command / AXI-Lite / response bundle (master modport)
//   busy       high whenever a command is in progress
//   txn_count  completed responses, wrapping
//   err_count  responses with non-zero resp, saturating
module axil_cmd_master #(
    parameter int unsigned CFGAW = 32,
    parameter int unsigned CFGDW = 32,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axil_cmd_master_if.master    bus,
    output logic                 busy,
    output logic [CNTW-1:0]      txn_count,
    output logic [CNTW-1:0]      err_count
);
    localparam int unsigned CMDW = 1 + CFGAW + CFGDW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RRESP = 3'd4,
        RSP   = 3'd5
    } state_t;

    state_t            state_q;
    logic [CFGAW-1:0]  awaddr_q;
    logic [CFGDW-1:0]  wdata_q;
    logic [CFGAW-1:0]  araddr_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              arvalid_q;
    logic [CFGDW-1:0]  rsp_data_q;
    logic [1:0]        rsp_resp_q;
    logic              rsp_write_q;
    logic              rsp_valid_q;
    logic [CNTW-1:0]   txn_q;
    logic [CNTW-1:0]   err_q;

    // Command field split
    logic              cmd_write;
    logic [CFGAW-1:0]  cmd_addr;
    logic [CFGDW-1:0]  cmd_data;
    assign cmd_write = bus.s_cmd_tdata[CMDW-1];
    assign cmd_addr  = bus.s_cmd_tdata[CFGDW +: CFGAW];
    assign cmd_data  = bus.s_cmd_tdata[CFGDW-1:0];

    // A write channel counts as done if it already completed or completes now
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || bus.m_axil_awready;
    assign w_done  = !wvalid_q  || bus.m_axil_wready;

    // Main FSM with registered address/data/valid/response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            txn_q       <= '0;
            err_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.s_cmd_tvalid) begin
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_data;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WRITE;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (awvalid_q && bus.m_axil_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && bus.m_axil_wready)   wvalid_q  <= 1'b0;
                    if (aw_done && w_done)               state_q   <= WRESP;
                end
                WRESP: begin
                    if (bus.m_axil_bvalid) begin
                        rsp_data_q  <= '0;
                        rsp_resp_q  <= bus.m_axil_bresp;
                        rsp_write_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                READ: begin
                    if (bus.m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= RRESP;
                    end
                end
                RRESP: begin
                    if (bus.m_axil_rvalid) begin
                        rsp_data_q  <= bus.m_axil_rdata;
                        rsp_resp_q  <= bus.m_axil_rresp;
                        rsp_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (bus.m_rsp_tready) begin
                        rsp_valid_q <= 1'b0;
                        txn_q       <= txn_q + CNTW'(1);
                        if ((rsp_resp_q != 2'b00) && (err_q != '1)) begin
                            err_q <= err_q + CNTW'(1);
                        end
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // State decodes (no input-to-output combinational path)
    assign bus.s_cmd_tready  = (state_q == IDLE);
    assign bus.m_axil_bready = (state_q == WRESP);
    assign bus.m_axil_rready = (state_q == RRESP);
    assign busy              = (state_q != IDLE);

    assign bus.m_axil_awaddr  = awaddr_q;
    assign bus.m_axil_awvalid = awvalid_q;
    assign bus.m_axil_wdata   = wdata_q;
    assign bus.m_axil_wvalid  = wvalid_q;
    assign bus.m_axil_araddr  = araddr_q;
    assign bus.m_axil_arvalid = arvalid_q;
    assign bus.m_rsp_tdata    = rsp_data_q;
    assign bus.m_rsp_tresp    = rsp_resp_q;
    assign bus.m_rsp_twrite   = rsp_write_q;
    assign bus.m_rsp_tvalid   = rsp_valid_q;
    assign txn_count          = txn_q;
    assign err_count          = err_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: register-file AXI-Lite slave with per-channel
// ready delays, response scoreboard, and a CNTW=2 twin for counter limits.
module tb_axil_cmd_master;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_cmd_master_if #(.CFGAW(AW), .CFGDW(DW)) bus ();
    axil_cmd_master_if #(.CFGAW(AW), .CFGDW(DW)) bus2 ();

    logic        busy, busy2;
    logic [15:0] txn, err;
    logic [1:0]  txn2, err2;

    axil_cmd_master #(.CFGAW(AW), .CFGDW(DW), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .txn_count(txn), .err_count(err)
    );

    // Twin with 2-bit counters fed the same inputs as u_dut
    axil_cmd_master #(.CFGAW(AW), .CFGDW(DW), .CNTW(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .busy(busy2), .txn_count(txn2), .err_count(err2)
    );
    assign bus2.s_cmd_tdata    = bus.s_cmd_tdata;
    assign bus2.s_cmd_tvalid   = bus.s_cmd_tvalid;
    assign bus2.m_axil_awready = bus.m_axil_awready;
    assign bus2.m_axil_wready  = bus.m_axil_wready;
    assign bus2.m_axil_bresp   = bus.m_axil_bresp;
    assign bus2.m_axil_bvalid  = bus.m_axil_bvalid;
    assign bus2.m_axil_arready = bus.m_axil_arready;
    assign bus2.m_axil_rdata   = bus.m_axil_rdata;
    assign bus2.m_axil_rresp   = bus.m_axil_rresp;
    assign bus2.m_axil_rvalid  = bus.m_axil_rvalid;
    assign bus2.m_rsp_tready   = bus.m_rsp_tready;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] model_mem [0:15];

    // ---------------- AXI-Lite slave model ----------------
    int unsigned aw_delay, w_delay, ar_delay;
    logic [1:0]  bresp_cfg, rresp_cfg;
    int unsigned aw_wait, w_wait, ar_wait;
    logic        aw_have, w_have;
    logic [31:0] aw_addr_s, w_data_s;
    logic [31:0] slv_mem [0:15];
    int          b_count = 0;

    assign bus.m_axil_awready = (aw_wait >= aw_delay);
    assign bus.m_axil_wready  = (w_wait >= w_delay);
    assign bus.m_axil_arready = (ar_wait >= ar_delay);

    logic aw_hs, w_hs, ar_hs, aw_now, w_now, do_wr;
    logic [31:0] wr_addr, wr_data;
    assign aw_hs   = bus.m_axil_awvalid && bus.m_axil_awready;
    assign w_hs    = bus.m_axil_wvalid && bus.m_axil_wready;
    assign ar_hs   = bus.m_axil_arvalid && bus.m_axil_arready;
    assign aw_now  = aw_have || aw_hs;
    assign w_now   = w_have || w_hs;
    assign do_wr   = aw_now && w_now && !bus.m_axil_bvalid;
    assign wr_addr = aw_have ? aw_addr_s : bus.m_axil_awaddr;
    assign wr_data = w_have ? w_data_s : bus.m_axil_wdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_have <= 1'b0; w_have <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0;
            bus.m_axil_bvalid <= 1'b0; bus.m_axil_bresp <= 2'b00;
            bus.m_axil_rvalid <= 1'b0; bus.m_axil_rresp <= 2'b00;
            bus.m_axil_rdata  <= '0;
        end else begin
            aw_wait <= (aw_hs || !bus.m_axil_awvalid) ? 0 : aw_wait + 1;
            w_wait  <= (w_hs  || !bus.m_axil_wvalid)  ? 0 : w_wait + 1;
            ar_wait <= (ar_hs || !bus.m_axil_arvalid) ? 0 : ar_wait + 1;
            if (do_wr) begin
                bus.m_axil_bvalid <= 1'b1;
                bus.m_axil_bresp  <= bresp_cfg;
                aw_have <= 1'b0;
                w_have  <= 1'b0;
            end else begin
                if (aw_hs) begin aw_have <= 1'b1; aw_addr_s <= bus.m_axil_awaddr; end
                if (w_hs)  begin w_have  <= 1'b1; w_data_s  <= bus.m_axil_wdata;  end
                if (bus.m_axil_bvalid && bus.m_axil_bready) bus.m_axil_bvalid <= 1'b0;
            end
            if (ar_hs) begin
                bus.m_axil_rvalid <= 1'b1;
                bus.m_axil_rdata  <= slv_mem[bus.m_axil_araddr[3:0]];
                bus.m_axil_rresp  <= rresp_cfg;
            end else if (bus.m_axil_rvalid && bus.m_axil_rready) begin
                bus.m_axil_rvalid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && do_wr) slv_mem[wr_addr[3:0]] <= wr_data;
        if (rst && bus.m_axil_bvalid && bus.m_axil_bready) b_count <= b_count + 1;
    end

    // ---------------- monitor: scoreboard + hold-while-valid ----------------
    logic        rsp_stall_p, aw_stall_p, w_stall_p, ar_stall_p;
    logic [34:0] rsp_saved;
    logic [31:0] aw_saved, w_saved, ar_saved;

    always @(negedge clk) begin
        if (!rst) begin
            rsp_stall_p = 1'b0; aw_stall_p = 1'b0; w_stall_p = 1'b0; ar_stall_p = 1'b0;
        end else begin
            if (rsp_stall_p)
                check("rsp_hold", {bus.m_rsp_tvalid, bus.m_rsp_twrite, bus.m_rsp_tresp, bus.m_rsp_tdata},
                      {1'b1, rsp_saved});
            if (aw_stall_p) check("awaddr_hold", {bus.m_axil_awvalid, bus.m_axil_awaddr}, {1'b1, aw_saved});
            if (w_stall_p)  check("wdata_hold",  {bus.m_axil_wvalid, bus.m_axil_wdata},   {1'b1, w_saved});
            if (ar_stall_p) check("araddr_hold", {bus.m_axil_arvalid, bus.m_axil_araddr}, {1'b1, ar_saved});
            rsp_stall_p = bus.m_rsp_tvalid && !bus.m_rsp_tready;
            rsp_saved   = {bus.m_rsp_twrite, bus.m_rsp_tresp, bus.m_rsp_tdata};
            aw_stall_p  = bus.m_axil_awvalid && !bus.m_axil_awready;
            aw_saved    = bus.m_axil_awaddr;
            w_stall_p   = bus.m_axil_wvalid && !bus.m_axil_wready;
            w_saved     = bus.m_axil_wdata;
            ar_stall_p  = bus.m_axil_arvalid && !bus.m_axil_arready;
            ar_saved    = bus.m_axil_araddr;
            if (bus.m_rsp_tvalid && bus.m_rsp_tready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp", {bus.m_rsp_twrite, bus.m_rsp_tresp, bus.m_rsp_tdata}, e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic push);
        rsp_t e;
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.s_cmd_tdata  = {w, a, d};
        bus.s_cmd_tvalid = 1'b1;
        if (push) begin
            e.wr   = w;
            e.resp = w ? bresp_cfg : rresp_cfg;
            e.data = w ? 32'd0 : model_mem[a[3:0]];
            exp_q.push_back(e);
        end
        if (w) model_mem[a[3:0]] = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.s_cmd_tready) begin ok = 1'b1; break; end
        end
        if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.s_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        check("idle_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    int b0;
    int exp_t, exp_e;

    initial begin
        rst = 1'b0;
        bus.s_cmd_tdata  = '0;
        bus.s_cmd_tvalid = 1'b0;
        bus.m_rsp_tready = 1'b1;
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cmd_tready", bus.s_cmd_tready, 1);
        check("rst_ctrl", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid, bus.m_axil_bready,
                           bus.m_axil_rready, bus.m_rsp_tvalid, busy}, 0);
        check("rst_wr_regs", {bus.m_axil_awaddr, bus.m_axil_wdata}, 0);
        check("rst_rsp", {bus.m_axil_araddr, bus.m_rsp_twrite, bus.m_rsp_tresp}, 0);
        check("rst_rsp_data", bus.m_rsp_tdata, 0);
        check("rst_counters", {txn, err}, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Write A5 to 3 with cycle-exact timing, then read it back
        send_cmd(1'b1, 32'd3, 32'h0000_00A5, 1'b1);
        @(negedge clk);
        check("t1_after_accept", {bus.m_axil_awvalid, bus.m_axil_wvalid, busy, bus.s_cmd_tready}, 4'b1110);
        check("t1_aw_w_payload", {bus.m_axil_awaddr, bus.m_axil_wdata}, {32'd3, 32'hA5});
        @(negedge clk);
        check("t1_wresp", {bus.m_axil_bready, bus.m_axil_awvalid, bus.m_axil_wvalid}, 3'b100);
        @(negedge clk);
        check("t1_rsp_valid", {bus.m_rsp_tvalid, bus.m_axil_bready}, 2'b10);
        @(negedge clk);
        check("t1_back_idle", {bus.s_cmd_tready, busy, bus.m_rsp_tvalid}, 3'b100);
        send_cmd(1'b0, 32'd3, 32'd0, 1'b1);
        wait_idle(50);
        check("t1_txn", txn, 2);

        // Delayed awready, immediate wready
        aw_delay = 3;
        b0 = b_count;
        send_cmd(1'b1, 32'd5, 32'h0000_1234, 1'b1);
        @(negedge clk);
        check("t2a_both_valid", {bus.m_axil_awvalid, bus.m_axil_wvalid}, 2'b11);
        @(negedge clk);
        check("t2a_w_dropped", {bus.m_axil_awvalid, bus.m_axil_wvalid}, 2'b10);
        wait_idle(50);
        check("t2a_one_b", 64'(b_count - b0), 1);

        // Immediate awready, delayed wready
        aw_delay = 0; w_delay = 3;
        b0 = b_count;
        send_cmd(1'b1, 32'd6, 32'h0000_5678, 1'b1);
        @(negedge clk);
        check("t2b_both_valid", {bus.m_axil_awvalid, bus.m_axil_wvalid}, 2'b11);
        @(negedge clk);
        check("t2b_aw_dropped", {bus.m_axil_awvalid, bus.m_axil_wvalid}, 2'b01);
        wait_idle(50);
        check("t2b_one_b", 64'(b_count - b0), 1);
        w_delay = 0;
        send_cmd(1'b0, 32'd5, 32'd0, 1'b1);
        wait_idle(50);
        send_cmd(1'b0, 32'd6, 32'd0, 1'b1);
        wait_idle(50);

        // SLVERR read with a stalled response consumer
        rresp_cfg = 2'b10;
        @(posedge clk); #1 bus.m_rsp_tready = 1'b0;
        send_cmd(1'b0, 32'd3, 32'd0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.m_rsp_tvalid) break;
        end
        for (int k = 0; k < 5; k++) begin
            check("t3_stalled", {bus.s_cmd_tready, bus.m_rsp_tvalid}, 2'b01);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.m_rsp_tready = 1'b1;
        wait_idle(50);
        check("t3_err", err, 1);
        check("t3_txn", txn, 7);
        rresp_cfg = 2'b00;

        // Reset while waiting for the write response
        b0 = b_count;
        send_cmd(1'b1, 32'd7, 32'h0000_0077, 1'b0);
        @(posedge clk); #1;
        check("t4_in_wresp", bus.m_axil_bready, 1);
        rst = 1'b0;
        #1;
        check("t4_ctrl_clear", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid, bus.m_axil_bready,
                                bus.m_axil_rready, bus.m_rsp_tvalid, busy, bus.s_cmd_tready}, 8'b0000_0001);
        check("t4_counters", {txn, err}, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_no_b", 64'(b_count - b0), 0);
        send_cmd(1'b0, 32'd5, 32'd0, 1'b1);
        wait_idle(50);
        check("t4_txn_after", {txn, err}, {16'd1, 16'd0});

        // 2-bit counters: wrap and saturate over five error writes
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_rst_cnt2", {txn2, err2}, 0);
        @(posedge clk); #1 rst = 1'b1;
        bresp_cfg = 2'b10;
        exp_t = 0; exp_e = 0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'b1, 32'(8 + i), 32'(i), 1'b1);
            wait_idle(50);
            exp_t = (exp_t + 1) % 4;
            if (exp_e < 3) exp_e = exp_e + 1;
            check("t5_txn2", txn2, 64'(exp_t));
            check("t5_err2", err2, 64'(exp_e));
            check("t5_txn16", txn, 64'(i + 1));
        end
        bresp_cfg = 2'b00;

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Command-to-AXI-Lite bridge that sits directly upstream of the AXI-Lite control/status register bank. It accepts single read or write commands on an AXI-Stream-style command port and issues exactly one AXI-Lite transaction per command. It returns the read data or the write response on a response stream and keeps transaction and error counters. Only one transaction is in flight at a time.

## Interface
Parameters:
- CFGAW, 32, AXI-Lite address width
- CFGDW, 32, AXI-Lite data width
- CNTW, 16, width of txn_count and err_count

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- s_cmd_tdata  in  1+CFGAW+CFGDW  {write, addr, data}; MSB=1 write, 0 read; data in LSBs, ignored for reads
- s_cmd_tvalid  in  1  command valid
- s_cmd_tready  out  1  command accepted
- m_axil_awaddr, m_axil_awvalid, m_axil_awready  out/out/in  CFGAW/1/1  write address channel
- m_axil_wdata, m_axil_wvalid, m_axil_wready  out/out/in  CFGDW/1/1  write data channel
- m_axil_bresp, m_axil_bvalid, m_axil_bready  in/in/out  2/1/1  write response channel
- m_axil_araddr, m_axil_arvalid, m_axil_arready  out/out/in  CFGAW/1/1  read address channel
- m_axil_rdata, m_axil_rresp, m_axil_rvalid, m_axil_rready  in/in/in/out  CFGDW/2/1/1  read data channel
- m_rsp_tdata  out  CFGDW  read data; 0 for writes
- m_rsp_tresp  out  2  captured bresp/rresp
- m_rsp_twrite  out  1  1 = response to a write command
- m_rsp_tvalid, m_rsp_tready  out/in  1/1  response handshake
- busy  out  1  high in every state except IDLE
- txn_count  out  CNTW  completed responses, wrapping
- err_count  out  CNTW  responses with tresp != 0, saturating

## Operation
- States: IDLE, WRITE, WRESP, READ, RRESP, RSP.
- IDLE: s_cmd_tready=1. On command handshake:
  - Register addr and data.
  - Write command: set awvalid=1 and wvalid=1, go to WRITE.
  - Read command: set arvalid=1, go to READ.
- WRITE: awvalid and wvalid each drop on their own handshake, so they can complete in the same cycle or in either order.
  - When both have completed (including the cycle of the last handshake), go to WRESP.
- WRESP: bready=1. On b handshake, capture bresp, set tdata=0 and twrite=1, set m_rsp_tvalid=1, go to RSP.
- READ: arvalid stays high until the ar handshake, then go to RRESP.
- RRESP: rready=1. On r handshake, capture rdata and rresp, set twrite=0, set m_rsp_tvalid=1, go to RSP.
- RSP: m_rsp_tvalid and all response fields stay stable until m_rsp_tready. On the handshake:
  - Clear tvalid.
  - Increment txn_count (wraps from all-ones to 0).
  - Increment err_count if tresp != 0 (holds at all-ones).
  - Go to IDLE.
- Address, data and valid outputs are registered. bready, rready, s_cmd_tready and busy decode from the state.
- awaddr, wdata and araddr hold their values while the matching valid is high.
- rresp/bresp values other than 0 pass through unchanged; the bridge never retries.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE.
  - All AXI valids, bready, rready, m_rsp_tvalid, busy = 0.
  - s_cmd_tready=1.
  - awaddr, wdata, araddr, m_rsp_tdata, tresp, twrite, counters = 0.
- Reset asserted mid-transaction: outputs clear immediately, with no waiting for a clock. The abandoned transaction produces no response.
- Command accepted at edge N: awvalid/wvalid (or arvalid) are high after edge N; busy=1 and s_cmd_tready=0 from edge N.
- Zero-wait slave: the aw, w, b, ar and r handshakes each take one cycle. For a write:
  - aw/w handshake at edge N+1.
  - bready high after edge N+1.
  - b handshake at edge N+2.
  - m_rsp_tvalid high after edge N+2.
  - With tready=1, the response handshake happens at edge N+3.
  - Next command accepted at edge N+4 (reads follow the same sequence).
- Command-to-response latency with a zero-wait slave and a zero-wait response consumer: 3 cycles for both reads and writes. Minimum command spacing is 4 cycles.
- bvalid or rvalid arriving early (before bready/rready are asserted) is held by the slave per AXI rules. No lookahead is required.
- No combinational path from any input to s_cmd_tready.

## Test plan
- Write 0x000000A5 to addr 3, then read addr 3, against a register-file model with zero-wait ready. Required:
  - Responses {twrite=1, tresp=0, tdata=0} then {twrite=0, tresp=0, tdata=0xA5}.
  - txn_count=2.
- Write with awready delayed 3 cycles and wready immediate, then the reverse. Required:
  - awvalid and wvalid each drop independently.
  - Exactly one b handshake per write.
  - awaddr/wdata stable while valid.
- Read with rresp=2 (SLVERR) and m_rsp_tready held low for 5 cycles. Required:
  - Response fields stable throughout.
  - s_cmd_tready=0 until the response handshake.
  - err_count=1.
- rst pulled low while in WRESP. Required:
  - All valids and ready outputs 0 immediately.
  - Counters 0.
  - After release, the next read completes normally.
- Preload the counters near all-ones (force or CNTW=2) and run 5 error transactions. Required:
  - txn_count wraps 3→0→1.
  - err_count saturates at 3.
